// File: rtl/controle_multiciclo.sv
// Multicycle sequencer for the RISC-V datapath: FETCH/DECODE/EXEC/MEM/WB control,
// data-memory ready handshake with timeout, halt on fault, cycle/retire counters.
module controle_multiciclo #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic             busy,
    output logic             halted,
    output logic [1:0]       err_code,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // wait counter only needs to reach MEM_TIMEOUT-1
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [6:0]        opc_q, opc_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]        err_q, err_d;
    logic [CNT_W-1:0]  instr_q, instr_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic              retire;
    logic              op_legal, is_ld, is_st, is_br;

    assign op_legal = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LD)
                   || (opcode == OP_ST) || (opcode == OP_BR);
    assign is_ld = (opc_q == OP_LD);
    assign is_st = (opc_q == OP_ST);
    assign is_br = (opc_q == OP_BR);

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        wait_d  = wait_q;
        err_d   = err_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                opc_d = opcode;
                if (op_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_HALT;
                    err_d   = ERR_ILLEGAL;
                end
            end
            S_EXEC: begin
                if (is_br) begin
                    retire  = 1'b1;
                    state_d = run ? S_FETCH : S_IDLE;
                end else if (is_ld || is_st) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // a ready on the final allowed cycle still completes the access
                if (mem_ready) begin
                    if (is_st) begin
                        retire  = 1'b1;
                        state_d = run ? S_FETCH : S_IDLE;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
        instr_d = instr_q + CNT_W'(retire);
        cycle_d = cycle_q + CNT_W'(busy);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            opc_q   <= '0;
            wait_q  <= '0;
            err_q   <= ERR_NONE;
            instr_q <= '0;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            instr_q <= instr_d;
            cycle_q <= cycle_d;
        end
    end

    // Moore decode; only pc_src (zero) and the store retire (mem_ready) see inputs
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            S_FETCH: ir_write = 1'b1;
            S_EXEC: begin
                alu_src  = !is_br && (opc_q != OP_R);
                pc_write = is_br;
                pc_src   = is_br && zero;
            end
            S_MEM: begin
                alu_src   = 1'b1;
                mem_read  = is_ld;
                mem_write = is_st;
                pc_write  = is_st && mem_ready;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_ld;
                pc_write   = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy        = (state_q >= S_FETCH) && (state_q <= S_WB);
    assign halted      = (state_q == S_HALT);
    assign err_code    = err_q;
    assign state       = state_q;
    assign instr_count = instr_q;
    assign cycle_count = cycle_q;

endmodule
